bullet_engine: RTL and testbench
================================

Name: bullet_engine

Overview:
Hardware bullet manager that sits directly upstream of the VGA display peripheral. It owns the bullet slot table: it spawns a bullet at the ship's nose on a fire request and advances every active bullet once per frame. It retires bullets that leave the screen. Its outputs drive the display's bullet X/Y and active-bitmap inputs directly, so software no longer writes per-bullet registers.

Parameters:
MAX_BULLETS, 5, number of bullet slots (1..8)
SHIP_WIDTH, 40, ship sprite width in hcount units; spawn X offset
SHIP_HEIGHT, 30, ship sprite height in lines; used for spawn Y centring
BULLET_SIZE, 4, bullet square size
SPEED, 8, hcount units added to each active bullet per frame
H_LIMIT, 1280, bullet retired when new X >= H_LIMIT
COOLDOWN_FRAMES, 6, frames after a spawn during which fire requests wait

Ports:
clk  input  1  system clock (50 MHz)
reset  input  1  synchronous, active-high
frame_tick  input  1  one-cycle pulse at start of vertical blank
fire  input  1  one-cycle fire request pulse
ship_x  input  11  current ship X (left edge)
ship_y  input  10  current ship Y (top edge)
bullet_x  output  11*MAX_BULLETS  packed X, slot i at [11*i+10:11*i]
bullet_y  output  10*MAX_BULLETS  packed Y, slot i at [10*i+9:10*i]
bullet_active  output  MAX_BULLETS  slot active bitmap
busy  output  1  high while the frame-update sweep runs
fire_dropped  output  1  one-cycle pulse: fire discarded because no slot was free

Behaviour:
- Reset: all bullet_x/bullet_y = 0; bullet_active = 0; busy = 0; fire_dropped = 0; cooldown = 0; fire_pend = 0; tick_pend = 0; FSM = IDLE. Reset mid-sweep aborts the sweep immediately.
- Request latching, every cycle regardless of state:
  - fire sets fire_pend.
  - frame_tick sets tick_pend.
  - Clearing a pending flag in the same cycle its pulse arrives leaves the flag set, so no request is lost.
- FSM states: IDLE, UPDATE, SPAWN.
- IDLE:
  - If tick_pend: clear tick_pend; decrement cooldown, saturating at 0; set slot index to 0; go to UPDATE; busy = 1 from the next cycle.
  - Else if fire_pend and cooldown == 0: go to SPAWN.
  - Else stay in IDLE. fire_pend stays latched while cooldown > 0.
  - Tick has priority over fire, so a bullet spawned this frame is not advanced until the next frame_tick.
- UPDATE: one slot per cycle, slot idx = 0..MAX_BULLETS-1.
  - If active: compute sum = {1'b0, x} + SPEED as a 12-bit value.
  - If sum >= H_LIMIT: clear active[idx] and leave X unchanged.
  - Otherwise X <= sum[10:0].
  - Inactive slots are untouched.
  - After the last slot: busy = 0, return to IDLE.
  - Sweep latency is exactly MAX_BULLETS cycles.
- SPAWN: single cycle.
  - Select the lowest-index slot with active == 0.
  - If one is found, write:
    - X <= ship_x + SHIP_WIDTH, 12-bit compute. If the result is >= H_LIMIT, no spawn occurs, and this is not a drop.
    - Y <= ship_y + SHIP_HEIGHT/2 - BULLET_SIZE/2, truncated to 10 bits.
    - Set active; cooldown <= COOLDOWN_FRAMES.
  - If all slots are active: pulse fire_dropped for one cycle; cooldown unchanged.
  - In all cases clear fire_pend, unless a new fire arrives in this cycle, and return to IDLE.
- ship_x/ship_y are sampled in the SPAWN cycle.
- Outputs are registered and change only in UPDATE/SPAWN cycles. The display samples them asynchronously; sweeps run during vblank, so there is no visible tearing.
- Multiple fire pulses before service collapse into one request.
- Multiple frame_ticks before service collapse into one sweep.

Test Plan:
1. Reset, then fire with ship_x=200, ship_y=240 → after ≤3 cycles: active=5'b00001, slot0 X=240, Y=253; fire_dropped stays 0.
2. Single bullet at X=240; apply 3 frame_ticks spaced 1000 cycles → X=248, 256, 264. busy is high for exactly 5 cycles after each tick.
3. Bullet at X=1270, frame_tick → 1278 (kept). Next frame_tick → sum 1286 ≥ 1280, so active bit cleared and X stays 1278.
4. Fire 6 times, each spaced 7 frame_ticks apart (cooldown respected) → slots 0..4 filled in order, active=5'b11111. The 6th fire produces a one-cycle fire_dropped pulse and active is unchanged.
5. Fire, then a second fire 2 frames later → second spawn is delayed until cooldown reaches 0, i.e. occurs right after the 6th tick following the first spawn.
6. fire and frame_tick asserted in the same cycle with one existing bullet at X=100 → sweep first (X=108), then new slot1 spawn. Also assert reset during UPDATE → all outputs return to 0 on the next cycle.

Source files
------------

// File: rtl/bullet_engine.sv
// Bullet slot manager feeding the VGA bullet layer: spawns at the ship nose on fire,
// advances every live bullet once per frame and retires those that leave the screen.
module bullet_engine #(
  parameter int unsigned MAX_BULLETS     = 5,
  parameter int unsigned SHIP_WIDTH      = 40,
  parameter int unsigned SHIP_HEIGHT     = 30,
  parameter int unsigned BULLET_SIZE     = 4,
  parameter int unsigned SPEED           = 8,
  parameter int unsigned H_LIMIT         = 1280,
  parameter int unsigned COOLDOWN_FRAMES = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        frame_tick,
  input  logic                        fire,
  input  logic [10:0]                 ship_x,
  input  logic [9:0]                  ship_y,
  output logic [11*MAX_BULLETS-1:0]   bullet_x,
  output logic [10*MAX_BULLETS-1:0]   bullet_y,
  output logic [MAX_BULLETS-1:0]      bullet_active,
  output logic                        busy,
  output logic                        fire_dropped
);

  localparam int unsigned X_W   = 11;
  localparam int unsigned Y_W   = 10;
  localparam int unsigned SUM_W = 12;
  localparam int unsigned IDX_W = (MAX_BULLETS > 1) ? $clog2(MAX_BULLETS) : 1;
  localparam int unsigned CD_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;

  localparam logic [SUM_W-1:0] LIMIT    = SUM_W'(H_LIMIT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_BULLETS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_UPDATE,
    S_SPAWN
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [X_W-1:0]         x_q [MAX_BULLETS];
  logic [X_W-1:0]         x_d [MAX_BULLETS];
  logic [Y_W-1:0]         y_q [MAX_BULLETS];
  logic [Y_W-1:0]         y_d [MAX_BULLETS];
  logic [MAX_BULLETS-1:0] act_q, act_d;
  logic [CD_W-1:0]        cool_q, cool_d;
  logic                   fire_pend_q, fire_pend_d;
  logic                   tick_pend_q, tick_pend_d;
  logic                   busy_q, busy_d;
  logic                   drop_q, drop_d;

  logic                   tick_clr, fire_clr;
  logic [SUM_W-1:0]       adv_sum, spawn_sum;
  logic [Y_W-1:0]         spawn_y;
  logic [IDX_W-1:0]       free_idx;
  logic                   free_found;

  // Datapath arithmetic for the slot under sweep and for a spawn at the ship nose
  assign adv_sum   = {1'b0, x_q[idx_q]} + SUM_W'(SPEED);
  assign spawn_sum = {1'b0, ship_x} + SUM_W'(SHIP_WIDTH);
  assign spawn_y   = ship_y + Y_W'(SHIP_HEIGHT / 2) - Y_W'(BULLET_SIZE / 2);

  // Lowest-index free slot (scan from the top so the lowest match wins)
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = int'(MAX_BULLETS) - 1; i >= 0; i--) begin
      if (!act_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  // Next-state and next-register values
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    x_d      = x_q;
    y_d      = y_q;
    act_d    = act_q;
    cool_d   = cool_q;
    drop_d   = 1'b0;
    tick_clr = 1'b0;
    fire_clr = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tick_pend_q) begin
          tick_clr = 1'b1;
          if (cool_q != '0) cool_d = cool_q - CD_W'(1);
          idx_d   = '0;
          state_d = S_UPDATE;
        end else if (fire_pend_q && (cool_q == '0)) begin
          state_d = S_SPAWN;
        end
      end

      S_UPDATE: begin
        if (act_q[idx_q]) begin
          if (adv_sum >= LIMIT) act_d[idx_q] = 1'b0;
          else                  x_d[idx_q]   = adv_sum[X_W-1:0];
        end
        if (idx_q == LAST_IDX) state_d = S_IDLE;
        else                   idx_d   = idx_q + IDX_W'(1);
      end

      S_SPAWN: begin
        fire_clr = 1'b1;
        state_d  = S_IDLE;
        if (!free_found) begin
          drop_d = 1'b1;
        end else if (spawn_sum < LIMIT) begin
          // A nose position past the right edge silently skips the spawn
          x_d[free_idx]   = spawn_sum[X_W-1:0];
          y_d[free_idx]   = spawn_y;
          act_d[free_idx] = 1'b1;
          cool_d          = CD_W'(COOLDOWN_FRAMES);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // A pulse arriving in the clearing cycle re-arms the flag
    tick_pend_d = (tick_pend_q & ~tick_clr) | frame_tick;
    fire_pend_d = (fire_pend_q & ~fire_clr) | fire;
    busy_d      = (state_d == S_UPDATE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      act_q       <= '0;
      cool_q      <= '0;
      fire_pend_q <= 1'b0;
      tick_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      drop_q      <= 1'b0;
      for (int i = 0; i < int'(MAX_BULLETS); i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      act_q       <= act_d;
      cool_q      <= cool_d;
      fire_pend_q <= fire_pend_d;
      tick_pend_q <= tick_pend_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
      x_q         <= x_d;
      y_q         <= y_d;
    end
  end

  for (genvar g = 0; g < int'(MAX_BULLETS); g++) begin : g_pack
    assign bullet_x[X_W*g +: X_W] = x_q[g];
    assign bullet_y[Y_W*g +: Y_W] = y_q[g];
  end

  assign bullet_active = act_q;
  assign busy          = busy_q;
  assign fire_dropped  = drop_q;

endmodule

// File: tb/tb_bullet_engine.sv
// Bench for bullet_engine: directed scenarios plus random fire/tick traffic,
// checked every cycle against a frame-level model of the bullet table.
module tb_bullet_engine;

  localparam int NB = 5;

  logic              clk;
  logic              reset;
  logic              frame_tick;
  logic              fire;
  logic [10:0]       ship_x;
  logic [9:0]        ship_y;
  logic [11*NB-1:0]  bullet_x;
  logic [10*NB-1:0]  bullet_y;
  logic [NB-1:0]     bullet_active;
  logic              busy;
  logic              fire_dropped;

  bullet_engine dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .fire          (fire),
    .ship_x        (ship_x),
    .ship_y        (ship_y),
    .bullet_x      (bullet_x),
    .bullet_y      (bullet_y),
    .bullet_active (bullet_active),
    .busy          (busy),
    .fire_dropped  (fire_dropped)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int drop_cnt = 0;

  // Model: bullet table plus request bookkeeping. A sweep is computed whole when it
  // starts; slot s shows its new value once s+1 sweep cycles have elapsed.
  int mx[NB], my[NB], nx[NB];
  bit mact[NB], nact[NB];
  int cool, prog;
  bit fpend, tpend, in_sweep, spawn_armed, drop_exp;

  task automatic model_spawn();
    int slot;
    int sx;
    slot = -1;
    for (int s = NB - 1; s >= 0; s--) if (!mact[s]) slot = s;
    sx = int'(ship_x) + 40;
    if (slot < 0) drop_exp = 1'b1;
    else if (sx < 1280) begin
      mx[slot]   = sx;
      my[slot]   = (int'(ship_y) + 15 - 2) % 1024;
      mact[slot] = 1'b1;
      cool       = 6;
    end
  endtask

  task automatic model_step();
    if (reset) begin
      for (int s = 0; s < NB; s++) begin
        mx[s] = 0; my[s] = 0; mact[s] = 1'b0;
      end
      cool = 0; prog = 0;
      fpend = 0; tpend = 0; in_sweep = 0; spawn_armed = 0; drop_exp = 0;
    end else begin
      drop_exp = 1'b0;
      if (in_sweep) begin
        prog++;
        if (prog == NB) begin
          in_sweep = 1'b0;
          mx = nx;
          mact = nact;
        end
      end else if (spawn_armed) begin
        spawn_armed = 1'b0;
        model_spawn();
        fpend = 1'b0;
      end else if (tpend) begin
        tpend = 1'b0;
        if (cool > 0) cool--;
        for (int s = 0; s < NB; s++) begin
          nx[s] = mx[s];
          nact[s] = mact[s];
          if (mact[s]) begin
            if (mx[s] + 8 >= 1280) nact[s] = 1'b0;
            else                   nx[s]   = mx[s] + 8;
          end
        end
        prog = 0;
        in_sweep = 1'b1;
      end else if (fpend && cool == 0) begin
        spawn_armed = 1'b1;
      end
      if (fire)       fpend = 1'b1;
      if (frame_tick) tpend = 1'b1;
    end
  endtask

  always @(posedge clk) model_step();

  task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    logic [11*NB-1:0] exp_x;
    logic [10*NB-1:0] exp_y;
    logic [NB-1:0]    exp_a;
    if (fire_dropped === 1'b1) drop_cnt++;
    if (chk_en) begin
      for (int s = 0; s < NB; s++) begin
        bit sweep_done;
        sweep_done = in_sweep && (s < prog);
        exp_x[11*s +: 11] = 11'(sweep_done ? nx[s] : mx[s]);
        exp_a[s]          = sweep_done ? nact[s] : mact[s];
        exp_y[10*s +: 10] = 10'(my[s]);
      end
      cmp("bullet_x", 64'(bullet_x), 64'(exp_x));
      cmp("bullet_y", 64'(bullet_y), 64'(exp_y));
      cmp("bullet_active", 64'(bullet_active), 64'(exp_a));
      cmp("busy", 64'(busy), 64'(in_sweep));
      cmp("fire_dropped", 64'(fire_dropped), 64'(drop_exp));
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(bit f, bit t);
    @(posedge clk); #1;
    fire = f; frame_tick = t;
    @(posedge clk); #1;
    fire = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) begin
      pulse(1'b0, 1'b1);
      step(10);
    end
  endtask

  int x0, bcnt, d0;

  initial begin
    reset = 1'b1; fire = 1'b0; frame_tick = 1'b0;
    ship_x = 11'd200; ship_y = 10'd240;
    step(3);
    chk_en = 1'b1;
    reset = 1'b0;
    check("reset_active", int'(bullet_active), 0);
    check("reset_busy", int'(busy), 0);

    // Spawn at the ship nose
    d0 = drop_cnt;
    pulse(1'b1, 1'b0);
    step(3);
    check("spawn_active", int'(bullet_active), 1);
    check("spawn_x", int'(bullet_x[10:0]), 240);
    check("spawn_y", int'(bullet_y[9:0]), 253);
    check("spawn_nodrop", drop_cnt - d0, 0);

    // Three widely spaced frames; busy window is one cycle per slot
    for (int k = 1; k <= 3; k++) begin
      pulse(1'b0, 1'b1);
      bcnt = 0;
      for (int c = 0; c < 1000; c++) begin
        @(negedge clk);
        if (busy) bcnt++;
      end
      step(1);
      check("advance_x", int'(bullet_x[10:0]), 240 + 8 * k);
      check("busy_cycles", bcnt, 5);
    end

    // Right-edge retirement
    do_reset();
    ship_x = 11'd1230; ship_y = 10'd100;
    pulse(1'b1, 1'b0);
    step(5);
    check("edge_spawn_x", int'(bullet_x[10:0]), 1270);
    ticks(1);
    check("edge_keep_x", int'(bullet_x[10:0]), 1278);
    check("edge_keep_act", int'(bullet_active), 1);
    ticks(1);
    check("edge_retire_act", int'(bullet_active), 0);
    check("edge_retire_x", int'(bullet_x[10:0]), 1278);

    // Fill all slots, sixth fire is dropped
    do_reset();
    ship_x = 11'd200; ship_y = 10'd240;
    d0 = drop_cnt;
    for (int k = 0; k < 6; k++) begin
      pulse(1'b1, 1'b0);
      step(5);
      ticks(7);
    end
    check("full_active", int'(bullet_active), 31);
    check("full_drops", drop_cnt - d0, 1);
    check("full_slot0_x", int'(bullet_x[10:0]), 576);
    check("full_slot4_x", int'(bullet_x[54:44]), 352);

    // Cooldown delays a second fire until the sixth frame after the first spawn
    do_reset();
    pulse(1'b1, 1'b0);
    step(5);
    ticks(2);
    pulse(1'b1, 1'b0);
    step(5);
    check("cool_wait_a", int'(bullet_active), 1);
    ticks(3);
    check("cool_wait_b", int'(bullet_active), 1);
    ticks(1);
    check("cool_release", int'(bullet_active), 3);

    // Simultaneous fire and tick: sweep first, then spawn
    do_reset();
    ship_x = 11'd12; ship_y = 10'd50;
    pulse(1'b1, 1'b0);
    step(5);
    ticks(6);
    check("pre_both_x", int'(bullet_x[10:0]), 100);
    pulse(1'b1, 1'b1);
    step(12);
    check("both_slot0_x", int'(bullet_x[10:0]), 108);
    check("both_slot1_x", int'(bullet_x[21:11]), 52);
    check("both_active", int'(bullet_active), 3);

    // Reset in the middle of a sweep
    pulse(1'b0, 1'b1);
    step(1);
    check("mid_sweep_busy", int'(busy), 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("abort_active", int'(bullet_active), 0);
    check("abort_x", int'(bullet_x[21:0]), 0);
    check("abort_busy", int'(busy), 0);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      fire       = ($urandom_range(0, 19) == 0);
      frame_tick = ($urandom_range(0, 39) == 0);
      reset      = ($urandom_range(0, 1999) == 0);
      if ($urandom_range(0, 7) == 0) begin
        ship_x = 11'($urandom_range(0, 1300));
        ship_y = 10'($urandom_range(0, 1023));
      end
    end
    fire = 1'b0; frame_tick = 1'b0; reset = 1'b0;
    step(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d failed so far", n_fail);
    $fatal(1);
  end

endmodule
